// File: rtl/mc_ctrl_pkg.sv
// mc_ctrl_pkg: shared encodings for the multi-cycle MIPS control unit.
//   opcode/funct constants, alu_op codes, operand/next-PC/dest/write-data
//   select codes, the controller state enum and the decoded instruction class.
package mc_ctrl_pkg;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BLEZ  = 6'h06;
  localparam logic [5:0] OP_BGTZ  = 6'h07;
  localparam logic [5:0] OP_ORI   = 6'h0d;
  localparam logic [5:0] OP_LUI   = 6'h0f;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2b;

  localparam logic [5:0] FN_SLL  = 6'h00;
  localparam logic [5:0] FN_JR   = 6'h08;
  localparam logic [5:0] FN_ADDU = 6'h21;
  localparam logic [5:0] FN_SUBU = 6'h23;

  localparam logic [3:0] ALU_ADD = 4'd0;
  localparam logic [3:0] ALU_SUB = 4'd1;
  localparam logic [3:0] ALU_OR  = 4'd2;
  localparam logic [3:0] ALU_CMP = 4'd3;
  localparam logic [3:0] ALU_SLL = 4'd4;
  localparam logic [3:0] ALU_SRA = 4'd5;

  localparam logic [1:0] A_RS   = 2'd0;
  localparam logic [1:0] A_RT   = 2'd1;
  localparam logic [1:0] A_ZEXT = 2'd2;

  localparam logic [2:0] B_RT    = 3'd0;
  localparam logic [2:0] B_ZEXT  = 3'd1;
  localparam logic [2:0] B_SEXT  = 3'd2;
  localparam logic [2:0] B_SHAMT = 3'd3;
  localparam logic [2:0] B_C16   = 3'd4;
  localparam logic [2:0] B_ZERO  = 3'd5;

  localparam logic [1:0] NPC_PC4 = 2'd0;
  localparam logic [1:0] NPC_BR  = 2'd1;
  localparam logic [1:0] NPC_J   = 2'd2;
  localparam logic [1:0] NPC_RS  = 2'd3;

  localparam logic [1:0] DST_RT = 2'd0;
  localparam logic [1:0] DST_RD = 2'd1;
  localparam logic [1:0] DST_RA = 2'd2;

  localparam logic [1:0] WD_ALU = 2'd0;
  localparam logic [1:0] WD_MEM = 2'd1;
  localparam logic [1:0] WD_PC  = 2'd2;

  typedef enum logic [2:0] {
    S_INIT, S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB
  } state_t;

  typedef enum logic [3:0] {
    I_NOP, I_ADDU, I_SUBU, I_SLL, I_JR, I_ORI, I_LUI, I_LW, I_SW,
    I_BEQ, I_JAL, I_BGTZ, I_BLEZ, I_ILL
  } iclass_t;

endpackage

// File: rtl/mc_ctrl_if.sv
// mc_ctrl_if: control-unit <-> datapath bundle.
//   master: the controller (drives ALU controls, strobes, selects, state).
//   slave : the datapath / memory side (drives instr, alu_out, mem_ready).
interface mc_ctrl_if;
  logic [31:0] instr;
  logic [31:0] alu_out;
  logic        mem_ready;
  logic [3:0]  alu_op;
  logic [1:0]  alu_a_sel;
  logic [2:0]  alu_b_sel;
  logic        ir_we, pc_we, reg_we, mem_req, mem_we;
  logic [1:0]  npc_sel, reg_dst, wd_sel;
  logic        illegal;
  logic [2:0]  state;

  modport master (
    input  instr, alu_out, mem_ready,
    output alu_op, alu_a_sel, alu_b_sel, ir_we, pc_we, reg_we, mem_req,
           mem_we, npc_sel, reg_dst, wd_sel, illegal, state
  );
  modport slave (
    output instr, alu_out, mem_ready,
    input  alu_op, alu_a_sel, alu_b_sel, ir_we, pc_we, reg_we, mem_req,
           mem_we, npc_sel, reg_dst, wd_sel, illegal, state
  );
endinterface

// File: rtl/mc_decode.sv
// mc_decode: combinational instruction classifier.
//   instr   in  32  IR contents
//   cls     out     instruction class
//   illegal out 1   class is unsupported
// Macro MC_CTRL_CMPBR_EN adds bgtz/blez (rt must be 0); otherwise they are illegal.
module mc_decode import mc_ctrl_pkg::*; (
  input  logic [31:0] instr,
  output iclass_t     cls,
  output logic        illegal
);
  logic [5:0] op, fn;
  assign op = instr[31:26];
  assign fn = instr[5:0];
`ifdef MC_CTRL_CMPBR_EN
  logic [4:0] rt;
  assign rt = instr[20:16];
`endif

  always_comb begin
    cls = I_ILL;
    case (op)
      OP_RTYPE: begin
        case (fn)
          // sll with every field zero is the canonical NOP
          FN_SLL:  cls = (instr == 32'd0) ? I_NOP : I_SLL;
          FN_JR:   cls = I_JR;
          FN_ADDU: cls = I_ADDU;
          FN_SUBU: cls = I_SUBU;
          default: cls = I_ILL;
        endcase
      end
      OP_ORI: cls = I_ORI;
      OP_LUI: cls = I_LUI;
      OP_LW:  cls = I_LW;
      OP_SW:  cls = I_SW;
      OP_BEQ: cls = I_BEQ;
      OP_JAL: cls = I_JAL;
`ifdef MC_CTRL_CMPBR_EN
      OP_BGTZ: cls = (rt == 5'd0) ? I_BGTZ : I_ILL;
      OP_BLEZ: cls = (rt == 5'd0) ? I_BLEZ : I_ILL;
`endif
      default: cls = I_ILL;
    endcase
  end

  assign illegal = (cls == I_ILL);
endmodule

// File: rtl/mc_ctrl.sv
// mc_ctrl: multi-cycle MIPS control FSM (INIT/FETCH/DECODE/EXEC/MEM/WB).
//   clk   in  system clock, rising edge
//   reset in  asynchronous active-high reset
//   bus   mc_ctrl_if.master: instr/alu_out/mem_ready in; ALU controls,
//         strobes, selects, illegal pulse and debug state out.
// Outputs are a pure function of state, instr and alu_out.
// Macro MC_CTRL_CMPBR_EN enables the bgtz/blez compare branches.
module mc_ctrl import mc_ctrl_pkg::*; (
  input  logic      clk,
  input  logic      reset,
  mc_ctrl_if.master bus
);
  state_t  st, st_nxt;
  iclass_t cls;
  logic    ill;
  logic [3:0] op_c;
  logic [1:0] a_c;
  logic [2:0] b_c;

  mc_decode u_dec (.instr(bus.instr), .cls(cls), .illegal(ill));

  always_ff @(posedge clk or posedge reset)
    if (reset) st <= S_INIT;
    else       st <= st_nxt;

  assign bus.state = st;

  // ALU controls per class; held through MEM and WB so the address/result stay stable
  always_comb begin
    op_c = ALU_ADD;
    a_c  = A_RS;
    b_c  = B_RT;
    case (cls)
      I_SUBU, I_BEQ: op_c = ALU_SUB;
      I_SLL:  begin op_c = ALU_SLL; a_c = A_RT;   b_c = B_SHAMT; end
      I_ORI:  begin op_c = ALU_OR;                b_c = B_ZEXT;  end
      I_LUI:  begin op_c = ALU_SLL; a_c = A_ZEXT; b_c = B_C16;   end
      I_LW, I_SW:     b_c = B_SEXT;
      I_BGTZ, I_BLEZ: begin op_c = ALU_CMP; b_c = B_ZERO; end
      default: ;
    endcase
  end

  always_comb begin
    st_nxt        = st;
    bus.alu_op    = '0;
    bus.alu_a_sel = '0;
    bus.alu_b_sel = '0;
    bus.ir_we     = 1'b0;
    bus.pc_we     = 1'b0;
    bus.reg_we    = 1'b0;
    bus.mem_req   = 1'b0;
    bus.mem_we    = 1'b0;
    bus.npc_sel   = NPC_PC4;
    bus.reg_dst   = DST_RT;
    bus.wd_sel    = WD_ALU;
    bus.illegal   = 1'b0;
    if (st == S_EXEC || st == S_MEM || st == S_WB) begin
      bus.alu_op    = op_c;
      bus.alu_a_sel = a_c;
      bus.alu_b_sel = b_c;
    end
    case (st)
      S_INIT:  st_nxt = S_FETCH;
      S_FETCH: begin
        bus.ir_we = 1'b1;
        bus.pc_we = 1'b1;
        st_nxt    = S_DECODE;
      end
      S_DECODE: begin
        bus.illegal = ill;
        st_nxt      = ill ? S_FETCH : S_EXEC;
      end
      S_EXEC: begin
        st_nxt = S_FETCH;
        case (cls)
          I_ADDU, I_SUBU, I_SLL, I_ORI, I_LUI: st_nxt = S_WB;
          I_LW, I_SW: st_nxt = S_MEM;
          I_JR: begin bus.pc_we = 1'b1; bus.npc_sel = NPC_RS; end
          I_BEQ: begin
            bus.pc_we   = (bus.alu_out == 32'd0);
            bus.npc_sel = NPC_BR;
          end
          I_JAL: begin
            bus.pc_we   = 1'b1;
            bus.npc_sel = NPC_J;
            bus.reg_we  = 1'b1;
            bus.reg_dst = DST_RA;
            bus.wd_sel  = WD_PC;
          end
`ifdef MC_CTRL_CMPBR_EN
          // compare returns 1 when rs > 0
          I_BGTZ: begin
            bus.pc_we   = (bus.alu_out == 32'd1);
            bus.npc_sel = NPC_BR;
          end
          I_BLEZ: begin
            bus.pc_we   = (bus.alu_out != 32'd1);
            bus.npc_sel = NPC_BR;
          end
`endif
          default: ;
        endcase
      end
      S_MEM: begin
        bus.mem_req = 1'b1;
        bus.mem_we  = (cls == I_SW);
        if (bus.mem_ready) st_nxt = (cls == I_SW) ? S_FETCH : S_WB;
      end
      S_WB: begin
        bus.reg_we  = 1'b1;
        bus.reg_dst = (cls == I_ADDU || cls == I_SUBU || cls == I_SLL) ? DST_RD : DST_RT;
        bus.wd_sel  = (cls == I_LW) ? WD_MEM : WD_ALU;
        st_nxt      = S_FETCH;
      end
      default: st_nxt = S_INIT;
    endcase
  end
endmodule

// File: tb/tb_mc_ctrl.sv
// tb_mc_ctrl: directed scoreboard bench for mc_ctrl. The stimulus process
// pushes the hand-computed output snapshot for each cycle; a monitor on the
// falling edge pops and compares against the DUT outputs.
module tb_mc_ctrl;
  import mc_ctrl_pkg::*;

  typedef struct packed {
    logic [2:0] st;
    logic [3:0] op;
    logic [1:0] a;
    logic [2:0] b;
    logic [4:0] stb;   // {ir_we, pc_we, reg_we, mem_req, mem_we}
    logic [1:0] npc;
    logic [1:0] dst;
    logic [1:0] wd;
    logic       ill;
  } obs_t;

  logic clk, reset;
  mc_ctrl_if bus();

  mc_ctrl dut (.clk(clk), .reset(reset), .bus(bus));

  obs_t  exp_q[$];
  string name_q[$];
  obs_t  act, e;
  string nm;
  int    errors = 0, checks = 0;

  assign act = {bus.state, bus.alu_op, bus.alu_a_sel, bus.alu_b_sel,
                bus.ir_we, bus.pc_we, bus.reg_we, bus.mem_req, bus.mem_we,
                bus.npc_sel, bus.reg_dst, bus.wd_sel, bus.illegal};

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: run did not end, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      e  = exp_q.pop_front();
      nm = name_q.pop_front();
      checks++;
      if (act !== e) begin
        errors++;
        $display("FAIL %s: got %h expected %h", nm, act, e);
      end
    end
  end

  function automatic obs_t mk(state_t s, logic [3:0] op, logic [1:0] a, logic [2:0] b,
                              logic [4:0] stb, logic [1:0] npc, logic [1:0] dst,
                              logic [1:0] wd, logic ill);
    obs_t o;
    o = {s, op, a, b, stb, npc, dst, wd, ill};
    return o;
  endfunction

  localparam obs_t Z = '0;   // INIT, every output low

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic put(input string n, input obs_t o);
    exp_q.push_back(o);
    name_q.push_back(n);
  endtask

  task automatic c(input string n, input logic [31:0] ao, input logic mr, input obs_t o);
    tick();
    bus.alu_out   = ao;
    bus.mem_ready = mr;
    put(n, o);
  endtask

  // FETCH cycle (IR loads word) followed by the DECODE cycle
  task automatic fd(input string n, input logic [31:0] w, input logic ill, input logic mr);
    tick();
    bus.instr     = w;
    bus.alu_out   = '0;
    bus.mem_ready = mr;
    put({n, " fetch"}, mk(S_FETCH, 0, 0, 0, 5'b11000, NPC_PC4, 0, 0, 0));
    c({n, " decode"}, 0, mr, mk(S_DECODE, 0, 0, 0, 0, 0, 0, 0, ill));
  endtask

  initial begin
    reset = 1'b0;
    bus.instr = '0;
    bus.alu_out = '0;
    bus.mem_ready = 1'b0;
    #2 reset = 1'b1;
    c("reset0", 0, 0, Z);
    c("reset1", 0, 0, Z);
    c("reset2", 0, 0, Z);
    tick(); reset = 1'b0; put("release init", Z);

    // addu $3,$1,$2
    fd("addu", 32'h00221821, 0, 0);
    c("addu exec", 0, 0, mk(S_EXEC, ALU_ADD, A_RS, B_RT, 0, 0, 0, 0, 0));
    c("addu wb", 0, 0, mk(S_WB, ALU_ADD, A_RS, B_RT, 5'b00100, 0, DST_RD, WD_ALU, 0));
    // subu $3,$1,$2
    fd("subu", 32'h00221823, 0, 0);
    c("subu exec", 0, 0, mk(S_EXEC, ALU_SUB, A_RS, B_RT, 0, 0, 0, 0, 0));
    c("subu wb", 0, 0, mk(S_WB, ALU_SUB, A_RS, B_RT, 5'b00100, 0, DST_RD, WD_ALU, 0));
    // ori $2,$1,0x1234
    fd("ori", 32'h34221234, 0, 0);
    c("ori exec", 0, 0, mk(S_EXEC, ALU_OR, A_RS, B_ZEXT, 0, 0, 0, 0, 0));
    c("ori wb", 0, 0, mk(S_WB, ALU_OR, A_RS, B_ZEXT, 5'b00100, 0, DST_RT, WD_ALU, 0));
    // lui $2,5
    fd("lui", 32'h3C020005, 0, 0);
    c("lui exec", 0, 0, mk(S_EXEC, ALU_SLL, A_ZEXT, B_C16, 0, 0, 0, 0, 0));
    c("lui wb", 0, 0, mk(S_WB, ALU_SLL, A_ZEXT, B_C16, 5'b00100, 0, DST_RT, WD_ALU, 0));
    // sll $2,$1,3
    fd("sll", 32'h000110C0, 0, 0);
    c("sll exec", 0, 0, mk(S_EXEC, ALU_SLL, A_RT, B_SHAMT, 0, 0, 0, 0, 0));
    c("sll wb", 0, 0, mk(S_WB, ALU_SLL, A_RT, B_SHAMT, 5'b00100, 0, DST_RD, WD_ALU, 0));

    // lw $2,4($1): mem_ready high before MEM must be ignored, then low 2 cycles
    fd("lw", 32'h8C220004, 0, 1);
    c("lw exec", 0, 1, mk(S_EXEC, ALU_ADD, A_RS, B_SEXT, 0, 0, 0, 0, 0));
    c("lw mem0", 0, 0, mk(S_MEM, ALU_ADD, A_RS, B_SEXT, 5'b00010, 0, 0, 0, 0));
    c("lw mem1", 0, 0, mk(S_MEM, ALU_ADD, A_RS, B_SEXT, 5'b00010, 0, 0, 0, 0));
    c("lw mem2", 0, 1, mk(S_MEM, ALU_ADD, A_RS, B_SEXT, 5'b00010, 0, 0, 0, 0));
    c("lw wb", 0, 0, mk(S_WB, ALU_ADD, A_RS, B_SEXT, 5'b00100, 0, DST_RT, WD_MEM, 0));
    // sw $2,8($1), W=0
    fd("sw", 32'hAC220008, 0, 0);
    c("sw exec", 0, 0, mk(S_EXEC, ALU_ADD, A_RS, B_SEXT, 0, 0, 0, 0, 0));
    c("sw mem", 0, 1, mk(S_MEM, ALU_ADD, A_RS, B_SEXT, 5'b00011, 0, 0, 0, 0));

    // beq taken / not taken
    fd("beq0", 32'h10220003, 0, 0);
    c("beq0 exec", 0, 0, mk(S_EXEC, ALU_SUB, A_RS, B_RT, 5'b01000, NPC_BR, 0, 0, 0));
    fd("beq5", 32'h10220003, 0, 0);
    c("beq5 exec", 5, 0, mk(S_EXEC, ALU_SUB, A_RS, B_RT, 5'b00000, NPC_BR, 0, 0, 0));
    // jal / jr / nop
    fd("jal", 32'h0C000010, 0, 0);
    c("jal exec", 0, 0, mk(S_EXEC, 0, 0, 0, 5'b01100, NPC_J, DST_RA, WD_PC, 0));
    fd("jr", 32'h03E00008, 0, 0);
    c("jr exec", 0, 0, mk(S_EXEC, 0, 0, 0, 5'b01000, NPC_RS, 0, 0, 0));
    fd("nop", 32'h00000000, 0, 0);
    c("nop exec", 0, 0, mk(S_EXEC, 0, 0, 0, 0, 0, 0, 0, 0));
    // illegal word goes straight back to FETCH
    fd("ill", 32'hFC000000, 1, 0);

`ifdef MC_CTRL_CMPBR_EN
    fd("bgtz-1", 32'h1C200004, 0, 0);
    c("bgtz-1 exec", 32'hFFFFFFFF, 0, mk(S_EXEC, ALU_CMP, A_RS, B_ZERO, 0, NPC_BR, 0, 0, 0));
    fd("bgtz1", 32'h1C200004, 0, 0);
    c("bgtz1 exec", 1, 0, mk(S_EXEC, ALU_CMP, A_RS, B_ZERO, 5'b01000, NPC_BR, 0, 0, 0));
    fd("blez1", 32'h18200004, 0, 0);
    c("blez1 exec", 1, 0, mk(S_EXEC, ALU_CMP, A_RS, B_ZERO, 0, NPC_BR, 0, 0, 0));
    fd("blez0", 32'h18200004, 0, 0);
    c("blez0 exec", 0, 0, mk(S_EXEC, ALU_CMP, A_RS, B_ZERO, 5'b01000, NPC_BR, 0, 0, 0));
`else
    fd("bgtz ill", 32'h1C200004, 1, 0);
    fd("blez ill", 32'h18200004, 1, 0);
`endif

    // sw interrupted by reset while waiting in MEM
    fd("swr", 32'hAC220008, 0, 0);
    c("swr exec", 0, 0, mk(S_EXEC, ALU_ADD, A_RS, B_SEXT, 0, 0, 0, 0, 0));
    c("swr mem", 0, 0, mk(S_MEM, ALU_ADD, A_RS, B_SEXT, 5'b00011, 0, 0, 0, 0));
    tick(); reset = 1'b1; put("swr async reset", Z);
    c("swr reset hold", 0, 1, Z);
    tick(); reset = 1'b0; put("swr release init", Z);
    fd("after reset", 32'h00221821, 0, 0);

    @(negedge clk); #1;
    if (exp_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain: got %0d pending expected 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
